// File: rtl/if_fetch_if.sv
// Fetch-side bundle: stall/branch control in, ROM request/response, IF/ID output pair.
// master = fetch unit, slave = pipeline/ROM side.
interface if_fetch_if;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    modport master (
        input  stall, branch_flag, branch_target, rom_ack, rom_data,
        output rom_ce, rom_addr, if_pc, if_inst, if_valid
    );

    modport slave (
        output stall, branch_flag, branch_target, rom_ack, rom_data,
        input  rom_ce, rom_addr, if_pc, if_inst, if_valid
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, one outstanding ROM request, one-entry skid on stall.
// if_valid rises one edge after rom_ack; stall holds the output and parks at most one extra word.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic         Clk,
    input  logic         Rst_n,
    if_fetch_if.master   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, FULL, KILL} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic        rom_ce_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_inst_q;
    logic        out_vld_q;
    logic [31:0] sk_pc_q;
    logic [31:0] sk_inst_q;
    logic        sk_vld_q;

    logic        slot_free;
    logic [31:0] pc_inc;

    assign slot_free = !out_vld_q || !bus.stall;
    assign pc_inc    = pc_q + PC_STEP;

    assign bus.rom_ce   = rom_ce_q;
    assign bus.rom_addr = req_addr_q;
    assign bus.if_pc    = out_pc_q;
    assign bus.if_inst  = out_inst_q;
    assign bus.if_valid = out_vld_q;

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            rom_ce_q   <= 1'b0;
            out_pc_q   <= 32'h0;
            out_inst_q <= 32'h0;
            out_vld_q  <= 1'b0;
            sk_pc_q    <= 32'h0;
            sk_inst_q  <= 32'h0;
            sk_vld_q   <= 1'b0;
        end else if (bus.branch_flag) begin
            pc_q      <= bus.branch_target;
            out_vld_q <= 1'b0;
            sk_vld_q  <= 1'b0;
            rom_ce_q  <= 1'b1;
            // An un-acked request cannot be withdrawn; drain it in KILL.
            if ((state_q == FETCH || state_q == KILL) && !bus.rom_ack) begin
                state_q <= KILL;
            end else begin
                state_q    <= FETCH;
                req_addr_q <= bus.branch_target;
            end
        end else begin
            if (out_vld_q && !bus.stall) begin
                out_vld_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    req_addr_q <= pc_q;
                    rom_ce_q   <= 1'b1;
                    state_q    <= FETCH;
                end
                FETCH: begin
                    if (bus.rom_ack) begin
                        pc_q <= pc_inc;
                        if (slot_free) begin
                            out_pc_q   <= req_addr_q;
                            out_inst_q <= bus.rom_data;
                            out_vld_q  <= 1'b1;
                            req_addr_q <= pc_inc;
                        end else begin
                            sk_pc_q   <= req_addr_q;
                            sk_inst_q <= bus.rom_data;
                            sk_vld_q  <= 1'b1;
                            rom_ce_q  <= 1'b0;
                            state_q   <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (!bus.stall) begin
                        out_pc_q   <= sk_pc_q;
                        out_inst_q <= sk_inst_q;
                        out_vld_q  <= 1'b1;
                        sk_vld_q   <= 1'b0;
                        req_addr_q <= pc_q;
                        rom_ce_q   <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                KILL: begin
                    if (bus.rom_ack) begin
                        req_addr_q <= pc_q;
                        state_q    <= FETCH;
                    end
                end
                default: begin
                    rom_ce_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then randomized stall/branch/latency against a stream model.
module tb_if_fetch;
    logic Clk   = 1'b0;
    logic Rst_n = 1'b1;

    if_fetch_if bus();

    if_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          n_deliv = 0;
    int          lat_fix = 0;
    int          lat     = 0;
    int          wcnt    = 0;
    bit          noisy   = 1'b0;
    logic [31:0] exp_pc  = 32'h0;
    bit          hold_pend, br_pend, req_pend;
    logic [31:0] hold_pc, hold_inst, req_addr_prev;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
    endfunction

    function automatic int next_lat();
        return (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 2));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge, check against expectations from the last edge, drive next inputs.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt);
        logic ack;
        @(negedge Clk);
        if (hold_pend) begin
            chk("hold_vld",  {31'b0, bus.if_valid}, 32'd1);
            chk("hold_pc",   bus.if_pc,   hold_pc);
            chk("hold_inst", bus.if_inst, hold_inst);
        end
        if (br_pend) chk("branch_clears_vld", {31'b0, bus.if_valid}, 32'd0);
        if (req_pend) begin
            chk("req_ce_held",   {31'b0, bus.rom_ce}, 32'd1);
            chk("req_addr_held", bus.rom_addr, req_addr_prev);
        end
        bus.stall         = st;
        bus.branch_flag   = br;
        bus.branch_target = tgt;
        if (bus.rom_ce) ack = (wcnt >= lat);
        else            ack = noisy && ($urandom_range(0, 1) == 1);
        bus.rom_ack  = ack;
        bus.rom_data = (bus.rom_ce && ack) ? rom_word(bus.rom_addr) : $urandom;
        if (bus.if_valid && !st) begin
            chk("deliv_pc",   bus.if_pc,   exp_pc);
            chk("deliv_inst", bus.if_inst, rom_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
        if (br) exp_pc = tgt;
        hold_pend     = bus.if_valid && st && !br;
        hold_pc       = bus.if_pc;
        hold_inst     = bus.if_inst;
        br_pend       = br;
        req_pend      = bus.rom_ce && !ack;
        req_addr_prev = bus.rom_addr;
        if (bus.rom_ce && ack) begin
            wcnt = 0;
            lat  = next_lat();
        end else if (bus.rom_ce) begin
            wcnt++;
        end
    endtask

    task automatic do_reset(input bit ack_pend);
        @(negedge Clk);
        Rst_n             = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_flag   = 1'b0;
        bus.branch_target = 32'h0;
        bus.rom_ack       = ack_pend;
        bus.rom_data      = $urandom;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_rom_ce",   {31'b0, bus.rom_ce},   32'd0);
        chk("rst_rom_addr", bus.rom_addr,          32'h0);
        chk("rst_if_pc",    bus.if_pc,             32'h0);
        chk("rst_if_inst",  bus.if_inst,           32'h0);
        chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
        Rst_n       = 1'b0;
        bus.rom_ack = 1'b0;
        exp_pc    = 32'h0;
        hold_pend = 1'b0;
        br_pend   = 1'b0;
        req_pend  = 1'b0;
        wcnt      = 0;
        lat       = next_lat();
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!bus.if_valid && k < 20) begin
            step(1'b0, 1'b0, 32'h0);
            k++;
        end
        chk(tag, {31'b0, bus.if_valid}, 32'd1);
    endtask

    initial begin
        bus.stall = 1'b0; bus.branch_flag = 1'b0; bus.branch_target = 32'h0;
        bus.rom_ack = 1'b0; bus.rom_data = 32'h0;

        // Zero-wait ROM: first request in the second cycle, then one instruction per cycle.
        lat_fix = 0;
        do_reset(1'b0);
        step(1'b0, 1'b0, 32'h0);
        chk("first_ce",   {31'b0, bus.rom_ce}, 32'd1);
        chk("first_addr", bus.rom_addr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("seq_vld",  {31'b0, bus.if_valid}, 32'd1);
            chk("seq_pc",   bus.if_pc, 32'(k * 4));
            chk("seq_inst", bus.if_inst, rom_word(32'(k * 4)));
        end

        // Three-cycle stall at pc 8: skid takes 12, ROM idles, then 12 and 16 follow.
        do_reset(1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("stall_pc", bus.if_pc, 32'h8);
            if (k > 0) chk("stall_ce_off", {31'b0, bus.rom_ce}, 32'd0);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("release_pc", bus.if_pc, 32'h8);
        step(1'b0, 1'b0, 32'h0);
        chk("skid_pc",     bus.if_pc, 32'hC);
        chk("resume_ce",   {31'b0, bus.rom_ce}, 32'd1);
        chk("resume_addr", bus.rom_addr, 32'h10);
        step(1'b0, 1'b0, 32'h0);
        chk("after_skid_pc", bus.if_pc, 32'h10);

        // Two-cycle ROM, branch while waiting: stale word must be dropped.
        lat_fix = 2;
        do_reset(1'b0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        wait_valid("kill_timeout");
        chk("kill_pc",   bus.if_pc,   32'h100);
        chk("kill_inst", bus.if_inst, rom_word(32'h100));

        // Branch coinciding with ack and stall.
        lat_fix = 0;
        do_reset(1'b0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200);
        step(1'b0, 1'b0, 32'h0);
        chk("brack_addr", bus.rom_addr, 32'h200);
        step(1'b0, 1'b0, 32'h0);
        chk("brack_vld", {31'b0, bus.if_valid}, 32'd1);
        chk("brack_pc",  bus.if_pc, 32'h200);

        // Reset while in FULL with ack asserted.
        do_reset(1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("full_ce_off", {31'b0, bus.rom_ce}, 32'd0);
        do_reset(1'b1);
        step(1'b0, 1'b0, 32'h0);
        chk("post_rst_addr", bus.rom_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("post_rst_pc", bus.if_pc, 32'h0);

        // PC wrap from the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        wait_valid("wrap_timeout");
        chk("wrap_pc0", bus.if_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_pc1", bus.if_pc, 32'h0);

        // Randomized traffic: variable latency, stalls, branches, spurious acks, occasional reset.
        lat_fix = -1;
        noisy   = 1'b1;
        do_reset(1'b0);
        n_deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 999) < 2) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                logic        st, br;
                logic [31:0] tgt;
                st = ($urandom_range(0, 99) < 35);
                br = ($urandom_range(0, 99) < 6);
                case ($urandom_range(0, 3))
                    0:       tgt = 32'hFFFF_FFF8;
                    1:       tgt = $urandom;
                    default: tgt = $urandom & 32'h0000_FFFC;
                endcase
                step(st, br, tgt);
            end
        end
        chk("progress", {31'b0, (n_deliv > 200)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end that produces the `if_pc` / `if_inst` pair consumed by the IF/ID pipeline register. It owns the program counter and issues one-outstanding requests to the instruction ROM. It holds a fetched instruction while the downstream stage is stalled, using a one-entry skid buffer. It redirects the PC on branches and discards stale ROM responses.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded at reset; first fetch address.
- `PC_STEP`, 4: PC increment per sequential fetch.

- `Clk`  in  1  rising-edge clock.
- `Rst_n`  in  1  synchronous reset, active-high: asserted (1) at a rising `Clk` edge resets the block.
- `stall`  in  1  downstream cannot accept; `if_valid` instruction must be held.
- `branch_flag`  in  1  one-cycle redirect request.
- `branch_target`  in  32  redirect address, sampled when `branch_flag`=1.
- `rom_ce`  out  1  ROM request valid.
- `rom_addr`  out  32  ROM request address, stable while `rom_ce`=1 and no `rom_ack`.
- `rom_ack`  in  1  ROM response valid; meaningful only while `rom_ce`=1.
- `rom_data`  in  32  instruction word, valid with `rom_ack`.
- `if_pc`  out  32  address of presented instruction.
- `if_inst`  out  32  presented instruction.
- `if_valid`  out  1  `if_pc` / `if_inst` hold a live instruction.

## Operation
- Registers: `pc` (next fetch address), `req_addr` (drives `rom_addr`), output slot (`if_pc`, `if_inst`, `if_valid`), skid slot (`sk_pc`, `sk_inst`, `sk_valid`).
- Consumption: an output instruction is consumed at any edge where `if_valid`=1 and `stall`=0.
- Output-slot free: `if_valid`=0, or `stall`=0 at that edge.
- Priority at each edge: reset > branch > ack / stall handling.
- States:
  - IDLE: `rom_ce`=0. Next state is FETCH with `req_addr`=`pc`.
  - FETCH: `rom_ce`=1.
    - On `rom_ack` with output slot free: load the output slot from `req_addr`/`rom_data`, set `if_valid`=1, `pc`+=`PC_STEP`, `req_addr`=new `pc`, stay in FETCH.
    - On `rom_ack` while `if_valid`=1 and `stall`=1: load the skid slot, `pc`+=`PC_STEP`, go to FULL.
    - No ack: hold, and keep `rom_addr` stable.
  - FULL: `rom_ce`=0. When `stall`=0, move skid to output (`if_valid`=1), clear `sk_valid`, set `req_addr`=`pc`, go to FETCH.
  - KILL: `rom_ce`=1 with the old `req_addr`. On `rom_ack`, discard the data, set `req_addr`=`pc`, go to FETCH.
- Branch (`branch_flag`=1): `pc` <= `branch_target`. Clear `if_valid` and `sk_valid` regardless of `stall`.
  - From FETCH without ack: go to KILL (the outstanding request must complete).
  - From FETCH with ack: the ack is discarded; `req_addr` <= `branch_target`; stay in FETCH.
  - From KILL without ack: stay in KILL with the new `pc`.
  - From KILL with ack: go to FETCH at `branch_target`.
  - From IDLE or FULL: go to FETCH with `req_addr` <= `branch_target`.
- Arithmetic: `pc` is 32-bit unsigned. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000. `branch_target` is not realigned.

## Timing
- Reset values: `rom_ce`=0, `rom_addr`=`RESET_PC`, `if_pc`=0, `if_inst`=0, `if_valid`=0, `sk_valid`=0, `pc`=`RESET_PC`, state IDLE.
- Reset asserted mid-operation overrides everything; any in-flight ack is ignored.
- First `rom_ce`=1 appears in the second cycle after reset deasserts.
- Latency: with a zero-wait ROM (ack in the same cycle as `rom_ce`), `if_valid` rises one edge after the ack. Sustained throughput is one instruction per cycle while `stall`=0.
- At most one outstanding ROM request. `rom_ce` stays high until `rom_ack`.
- Stall: at most one extra instruction is accepted (into the skid slot); no further request issues while `sk_valid`=1.
- On a branch, `if_valid`=0 at the following edge. The first target instruction appears at least one cycle after its ack.
- After `stall` falls in FULL, the skid instruction is presented at the next edge, and the fetch request resumes in the same cycle.

## Test plan
- Reset then run, ROM acks every cycle, `stall`=0 → `if_pc` sequence 0, 4, 8, 12 on consecutive cycles; `if_inst` matches ROM contents.
- `stall`=1 for 3 cycles while `if_valid`=1 at `if_pc`=8 → `if_pc`=8 held, skid holds 12, `rom_ce`=0. On release, 12 then 16 follow with no gap or duplicate.
- ROM with 2-cycle latency, `branch_flag`=1 with target 32'h100 during the wait → stale ack discarded, next `if_pc`=32'h100, no instruction from the old path appears.
- Branch in the same cycle as ack and `stall`=1 → `if_valid`=0 next cycle, skid empty, next delivered `if_pc`=target.
- `Rst_n` asserted while in FULL with a pending ack → all outputs return to reset values, next fetch at `RESET_PC`.
- `branch_target`=32'hFFFF_FFFC, run 2 fetches → `if_pc` 32'hFFFF_FFFC then 32'h0000_0000.
